trb_port_scheduler: RTL and testbench

//  Time-multiplexes the single-port trace buffer RAM between the logger write stream, the logger read stream and a

---
 rtl/trb_port_scheduler_pkg.sv | 13 +
 rtl/trb_port_scheduler_if.sv | 56 +++++
 rtl/trb_port_scheduler_occ.sv | 37 +++
 rtl/trb_port_scheduler.sv | 99 +++++++++
 tb/tb_trb_port_scheduler.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/trb_port_scheduler_pkg.sv
// Shared constants and types for the trace buffer port scheduler.
// Provides default RAM geometry and the read-response owner tag.
package trb_port_scheduler_pkg;

    localparam int TRB_DEPTH = 64;
    localparam int TRB_WIDTH = 32;

    typedef enum logic {
        OWN_LOG  = 1'b0,
        OWN_HOST = 1'b1
    } rd_owner_t;

endpackage

// File: rtl/trb_port_scheduler_if.sv
// Bundle of logger, host and RAM-side signals around the scheduler.
// slave: scheduler view; master: logger/host/RAM environment view.
interface trb_port_scheduler_if #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              MODE_I;
    logic              CLEAR_I;
    logic              RW_TURN_O;
    logic              WRITE_I;
    logic [ADDR_W-1:0] WRITE_PTR_I;
    logic [WIDTH-1:0]  WDATA_I;
    logic              WRITE_ALLOW_O;
    logic              LOG_READ_I;
    logic [ADDR_W-1:0] READ_PTR_I;
    logic              READ_ALLOW_O;
    logic [WIDTH-1:0]  LOG_RDATA_O;
    logic              LOG_RVALID_O;
    logic              HOST_REQ_I;
    logic [ADDR_W-1:0] HOST_ADDR_I;
    logic              HOST_GNT_O;
    logic [WIDTH-1:0]  HOST_RDATA_O;
    logic              HOST_RVALID_O;
    logic              MEM_EN_O;
    logic              MEM_WE_O;
    logic [ADDR_W-1:0] MEM_ADDR_O;
    logic [WIDTH-1:0]  MEM_WDATA_O;
    logic [WIDTH-1:0]  MEM_RDATA_I;

    modport slave (
        input  MODE_I, CLEAR_I,
        input  WRITE_I, WRITE_PTR_I, WDATA_I,
        input  LOG_READ_I, READ_PTR_I,
        input  HOST_REQ_I, HOST_ADDR_I,
        input  MEM_RDATA_I,
        output RW_TURN_O, WRITE_ALLOW_O, READ_ALLOW_O,
        output LOG_RDATA_O, LOG_RVALID_O,
        output HOST_GNT_O, HOST_RDATA_O, HOST_RVALID_O,
        output MEM_EN_O, MEM_WE_O, MEM_ADDR_O, MEM_WDATA_O
    );

    modport master (
        output MODE_I, CLEAR_I,
        output WRITE_I, WRITE_PTR_I, WDATA_I,
        output LOG_READ_I, READ_PTR_I,
        output HOST_REQ_I, HOST_ADDR_I,
        output MEM_RDATA_I,
        input  RW_TURN_O, WRITE_ALLOW_O, READ_ALLOW_O,
        input  LOG_RDATA_O, LOG_RVALID_O,
        input  HOST_GNT_O, HOST_RDATA_O, HOST_RVALID_O,
        input  MEM_EN_O, MEM_WE_O, MEM_ADDR_O, MEM_WDATA_O
    );

endinterface

// File: rtl/trb_port_scheduler_occ.sv
// Word-occupancy counter for the trace buffer (0..DEPTH).
// Ports: i_clk, i_rst_n, i_inc, i_dec, i_clear, i_mode -> o_wr_allow, o_empty.
module trb_occupancy_counter #(
    parameter int DEPTH = 64
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_inc,
    input  logic i_dec,
    input  logic i_clear,
    input  logic i_mode,
    output logic o_wr_allow,
    output logic o_empty
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_full;

    assign w_full     = (r_cnt == CNT_W'(DEPTH));
    assign o_empty    = (r_cnt == '0);
    // Trace mode always accepts; a write into a full ring overwrites.
    assign o_wr_allow = i_mode ? ~w_full : 1'b1;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            if (!w_full) r_cnt <= r_cnt + 1'b1;
        end else if (i_dec) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/trb_port_scheduler.sv
// Shares one single-port trace RAM between logger writes, logger reads
// and host reads. Ports: CLK_I, RST_NI, bus (trb_port_scheduler_if.slave).
module trb_port_scheduler
    import trb_port_scheduler_pkg::*;
#(
    parameter int DEPTH = TRB_DEPTH,
    parameter int WIDTH = TRB_WIDTH
) (
    input  logic                 CLK_I,
    input  logic                 RST_NI,
    trb_port_scheduler_if.slave  bus
);
    logic             r_turn;
    rd_owner_t        r_rr;
    rd_owner_t        r_tag;
    logic             r_rsp_vld;
    logic [WIDTH-1:0] r_log_hold;
    logic [WIDTH-1:0] r_host_hold;

    logic w_wr_allow;
    logic w_empty;
    logic w_write;
    logic w_req_log;
    logic w_req_host;
    logic w_gnt_log;
    logic w_gnt_host;
    logic w_log_rv;
    logic w_host_rv;

    trb_occupancy_counter #(
        .DEPTH(DEPTH)
    ) u_occ (
        .i_clk      (CLK_I),
        .i_rst_n    (RST_NI),
        .i_inc      (w_write),
        .i_dec      (w_gnt_log),
        .i_clear    (bus.CLEAR_I),
        .i_mode     (bus.MODE_I),
        .o_wr_allow (w_wr_allow),
        .o_empty    (w_empty)
    );

    // Requests are masked while reset is held so nothing reaches the RAM.
    assign w_write    = RST_NI & r_turn & bus.WRITE_I & w_wr_allow;
    assign w_req_log  = RST_NI & ~r_turn & bus.LOG_READ_I & ~w_empty;
    assign w_req_host = RST_NI & ~r_turn & bus.HOST_REQ_I;

    // On contention the side not named by r_rr wins.
    assign w_gnt_host = w_req_host & (~w_req_log | (r_rr == OWN_LOG));
    assign w_gnt_log  = w_req_log & ~w_gnt_host;

    assign w_log_rv  = RST_NI & r_rsp_vld & (r_tag == OWN_LOG);
    assign w_host_rv = RST_NI & r_rsp_vld & (r_tag == OWN_HOST);

    assign bus.RW_TURN_O     = r_turn;
    assign bus.WRITE_ALLOW_O = w_wr_allow;
    assign bus.READ_ALLOW_O  = ~w_empty;
    assign bus.HOST_GNT_O    = w_gnt_host;

    assign bus.MEM_EN_O    = w_write | w_gnt_log | w_gnt_host;
    assign bus.MEM_WE_O    = w_write;
    assign bus.MEM_WDATA_O = bus.WDATA_I;
    assign bus.MEM_ADDR_O  = r_turn     ? bus.WRITE_PTR_I :
                             w_gnt_host ? bus.HOST_ADDR_I :
                                          bus.READ_PTR_I;

    assign bus.LOG_RVALID_O  = w_log_rv;
    assign bus.HOST_RVALID_O = w_host_rv;
    // Read data is forwarded in the response cycle and held afterwards.
    assign bus.LOG_RDATA_O  = !RST_NI  ? '0 :
                              w_log_rv ? bus.MEM_RDATA_I : r_log_hold;
    assign bus.HOST_RDATA_O = !RST_NI   ? '0 :
                              w_host_rv ? bus.MEM_RDATA_I : r_host_hold;

    always_ff @(posedge CLK_I) begin
        if (!RST_NI) begin
            r_turn      <= 1'b1;
            r_rr        <= OWN_LOG;
            r_tag       <= OWN_LOG;
            r_rsp_vld   <= 1'b0;
            r_log_hold  <= '0;
            r_host_hold <= '0;
        end else begin
            r_turn    <= ~r_turn;
            r_rsp_vld <= w_gnt_log | w_gnt_host;
            r_tag     <= w_gnt_host ? OWN_HOST : OWN_LOG;
            if (bus.CLEAR_I) begin
                r_rr <= OWN_LOG;
            end else if (w_gnt_host) begin
                r_rr <= OWN_HOST;
            end else if (w_gnt_log) begin
                r_rr <= OWN_LOG;
            end
            if (w_log_rv)  r_log_hold  <= bus.MEM_RDATA_I;
            if (w_host_rv) r_host_hold <= bus.MEM_RDATA_I;
        end
    end

endmodule

// File: tb/tb_trb_port_scheduler.sv
// Self-checking bench for trb_port_scheduler with DEPTH=8.
// Per-cycle model comparison plus directed literal expectations.
module tb_trb_port_scheduler;
    localparam int DEPTH = 8;
    localparam int WIDTH = 32;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    int   we_cnt;

    trb_port_scheduler_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    trb_port_scheduler #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .CLK_I  (clk),
        .RST_NI (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] ram [DEPTH];
    logic [31:0] mir [DEPTH];

    always @(posedge clk) begin
        if (bus.MEM_EN_O) begin
            if (bus.MEM_WE_O) ram[bus.MEM_ADDR_O] <= bus.MEM_WDATA_O;
            else bus.MEM_RDATA_I <= ram[bus.MEM_ADDR_O];
        end
        if (bus.MEM_WE_O) we_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: occupancy, last winner, pending response.
    bit   m_known;
    bit   m_turn;
    int   m_cnt;
    bit   m_last_host;
    bit   m_pv;
    bit   m_ph;
    logic [31:0] m_pd;
    logic [31:0] m_lhold;
    logic [31:0] m_hhold;

    always @(negedge clk) begin
        bit e_wa, e_ra, e_wr, e_rl, e_rh, e_gh, e_gl, e_en;
        logic [31:0] e_addr, e_lrd, e_hrd;
        if (m_known) begin
            e_wa = bus.MODE_I ? (m_cnt != DEPTH) : 1'b1;
            e_ra = (m_cnt != 0);
            e_wr = rst_n && m_turn && bus.WRITE_I && e_wa;
            e_rl = rst_n && !m_turn && bus.LOG_READ_I && e_ra;
            e_rh = rst_n && !m_turn && bus.HOST_REQ_I;
            e_gh = e_rh && (!e_rl || !m_last_host);
            e_gl = e_rl && !e_gh;
            e_en = e_wr || e_gh || e_gl;
            e_addr = e_wr ? 32'(bus.WRITE_PTR_I) :
                     e_gh ? 32'(bus.HOST_ADDR_I) : 32'(bus.READ_PTR_I);
            e_lrd = !rst_n ? 32'h0 : (m_pv && !m_ph) ? m_pd : m_lhold;
            e_hrd = !rst_n ? 32'h0 : (m_pv && m_ph) ? m_pd : m_hhold;
            chk("turn", bus.RW_TURN_O, m_turn);
            chk("wr_allow", bus.WRITE_ALLOW_O, e_wa);
            chk("rd_allow", bus.READ_ALLOW_O, e_ra);
            chk("mem_en", bus.MEM_EN_O, e_en);
            chk("mem_we", bus.MEM_WE_O, e_wr);
            chk("host_gnt", bus.HOST_GNT_O, e_gh);
            if (e_en) chk("mem_addr", 32'(bus.MEM_ADDR_O), e_addr);
            if (e_wr) chk("mem_wdata", bus.MEM_WDATA_O, bus.WDATA_I);
            chk("log_rvalid", bus.LOG_RVALID_O, rst_n && m_pv && !m_ph);
            chk("host_rvalid", bus.HOST_RVALID_O, rst_n && m_pv && m_ph);
            chk("log_rdata", bus.LOG_RDATA_O, e_lrd);
            chk("host_rdata", bus.HOST_RDATA_O, e_hrd);
            if (rst_n) begin
                if (m_pv && !m_ph) m_lhold = m_pd;
                if (m_pv && m_ph) m_hhold = m_pd;
                m_pv = e_gh || e_gl;
                m_ph = e_gh;
                m_pd = mir[e_addr[2:0]];
                if (e_wr) mir[bus.WRITE_PTR_I] = bus.WDATA_I;
                if (bus.CLEAR_I) m_cnt = 0;
                else if (e_wr) m_cnt = (m_cnt < DEPTH) ? m_cnt + 1 : DEPTH;
                else if (e_gl) m_cnt = m_cnt - 1;
                if (bus.CLEAR_I) m_last_host = 0;
                else if (e_gh || e_gl) m_last_host = e_gh;
                m_turn = !m_turn;
            end
        end
        if (!rst_n) begin
            m_known = 1; m_turn = 1; m_cnt = 0; m_last_host = 0;
            m_pv = 0; m_lhold = 0; m_hhold = 0;
        end
    end

    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_turn(input logic t);
        int n = 0;
        while (bus.RW_TURN_O !== t && n < 4) begin
            next_cyc();
            n++;
        end
        if (n >= 4) chk("turn_timeout", bus.RW_TURN_O, t);
    endtask

    task automatic do_write(input int a, input logic [31:0] d);
        wait_turn(1'b1);
        bus.WRITE_I = 1'b1;
        bus.WRITE_PTR_I = a[2:0];
        bus.WDATA_I = d;
        next_cyc();
        bus.WRITE_I = 1'b0;
    endtask

    task automatic do_read(input bit lg, input bit hs, input int la,
                           input int ha, input bit clr, output bit gnt);
        wait_turn(1'b0);
        bus.LOG_READ_I = lg;
        bus.HOST_REQ_I = hs;
        bus.READ_PTR_I = la[2:0];
        bus.HOST_ADDR_I = ha[2:0];
        bus.CLEAR_I = clr;
        #1;
        gnt = bus.HOST_GNT_O;
        next_cyc();
        bus.LOG_READ_I = 1'b0;
        bus.HOST_REQ_I = 1'b0;
        bus.CLEAR_I = 1'b0;
    endtask

    task automatic do_clear;
        bus.CLEAR_I = 1'b1;
        next_cyc();
        bus.CLEAR_I = 1'b0;
    endtask

    initial begin
        int w0;
        int nrd;
        bit g;
        logic [3:0] seq;
        n_chk = 0; n_fail = 0; we_cnt = 0; m_known = 0;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = 32'hA0 + i;
            mir[i] = 32'hA0 + i;
        end
        rst_n = 1'b0;
        bus.MODE_I = 1'b1; bus.CLEAR_I = 1'b0;
        bus.WRITE_I = 1'b0; bus.WRITE_PTR_I = '0; bus.WDATA_I = '0;
        bus.LOG_READ_I = 1'b0; bus.READ_PTR_I = '0;
        bus.HOST_REQ_I = 1'b0; bus.HOST_ADDR_I = '0;
        bus.MEM_RDATA_I = '0;
        repeat (3) next_cyc();
        rst_n = 1'b1;
        #1;
        chk("rst_turn", bus.RW_TURN_O, 1'b1);
        chk("rst_wa", bus.WRITE_ALLOW_O, 1'b1);
        chk("rst_ra", bus.READ_ALLOW_O, 1'b0);
        chk("rst_en", bus.MEM_EN_O, 1'b0);
        next_cyc();
        chk("idle_turn0", bus.RW_TURN_O, 1'b0);
        next_cyc();
        chk("idle_turn1", bus.RW_TURN_O, 1'b1);

        w0 = we_cnt;
        for (int i = 0; i < 8; i++) do_write(i, 32'h10 + i);
        chk("stream_full_wa", bus.WRITE_ALLOW_O, 1'b0);
        do_write(0, 32'hFF);
        next_cyc();
        chk("stream_we_cnt", we_cnt - w0, 8);

        do_clear();
        bus.MODE_I = 1'b0;
        w0 = we_cnt;
        for (int i = 0; i < 12; i++) do_write(i % 8, 32'h20 + i);
        next_cyc();
        chk("trace_we_cnt", we_cnt - w0, 12);
        chk("trace_wa", bus.WRITE_ALLOW_O, 1'b1);

        seq = '0;
        for (int i = 0; i < 4; i++) begin
            do_read(1'b1, 1'b1, 1, 5, 1'b0, g);
            seq = {seq[2:0], g};
        end
        next_cyc();
        chk("rr_seq", seq, 4'b1010);
        chk("host_data", bus.HOST_RDATA_O, 32'h25);
        chk("log_data", bus.LOG_RDATA_O, 32'h29);

        nrd = 0;
        while (bus.READ_ALLOW_O && nrd < 20) begin
            do_read(1'b1, 1'b0, 0, 0, 1'b0, g);
            nrd++;
        end
        chk("drain_reads", nrd, 6);

        do_write(2, 32'h55);
        do_read(1'b0, 1'b1, 0, 2, 1'b1, g);
        chk("clr_gnt", g, 1'b1);
        chk("clr_hvalid", bus.HOST_RVALID_O, 1'b1);
        chk("clr_hdata", bus.HOST_RDATA_O, 32'h55);
        chk("clr_ra", bus.READ_ALLOW_O, 1'b0);

        do_write(3, 32'h66);
        do_read(1'b1, 1'b0, 3, 0, 1'b0, g);
        rst_n = 1'b0;
        #1;
        chk("rst_lvalid", bus.LOG_RVALID_O, 1'b0);
        next_cyc();
        rst_n = 1'b1;
        #1;
        chk("rel_turn", bus.RW_TURN_O, 1'b1);
        chk("rel_ra", bus.READ_ALLOW_O, 1'b0);
        repeat (4) next_cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
